// File: rtl/serial_bk_adder_32b_pkg.sv
// Shared types and constants for the byte-serial Brent-Kung adder.
package serial_adder_pkg;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned NUM_BYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_bk_adder_32b_if.sv
// Operand/result handshake bundle for the byte-serial adder.
interface serial_bk_adder_32b_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned NUM_BYTES = NUM_BYTES_DEFAULT
);

  logic                        valid_i;
  logic                        ready_o;
  logic [BYTE_W*NUM_BYTES-1:0] op1_i;
  logic [BYTE_W*NUM_BYTES-1:0] op2_i;
  logic                        carry_i;
  logic                        valid_o;
  logic                        ready_i;
  logic [BYTE_W*NUM_BYTES-1:0] sum_o;
  logic                        carry_o;
  logic                        ovf_o;

  modport master (
    output valid_i, op1_i, op2_i, carry_i, ready_i,
    input  ready_o, valid_o, sum_o, carry_o, ovf_o
  );

  modport slave (
    input  valid_i, op1_i, op2_i, carry_i, ready_i,
    output ready_o, valid_o, sum_o, carry_o, ovf_o
  );

endinterface

// File: rtl/serial_bk_adder_32b_bk8.sv
// 8-bit Brent-Kung parallel-prefix adder with carry-in.
module brent_kung_adder_8b (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic [7:0] w_g, w_p;
  logic [7:0] w_gg, w_pp;
  logic [8:0] w_c;
  logic w_g10, w_p10, w_g32, w_p32, w_g54, w_p54, w_g76, w_p76;
  logic w_g30, w_p30, w_g74, w_p74, w_g70, w_p70;
  logic w_g50, w_p50, w_g20, w_p20, w_g40, w_p40, w_g60, w_p60;

  // Up-sweep builds power-of-two spans, down-sweep fills the remaining prefixes.
  always_comb begin
    w_g = i_a & i_b;
    w_p = i_a ^ i_b;

    w_g10 = w_g[1] | (w_p[1] & w_g[0]);  w_p10 = w_p[1] & w_p[0];
    w_g32 = w_g[3] | (w_p[3] & w_g[2]);  w_p32 = w_p[3] & w_p[2];
    w_g54 = w_g[5] | (w_p[5] & w_g[4]);  w_p54 = w_p[5] & w_p[4];
    w_g76 = w_g[7] | (w_p[7] & w_g[6]);  w_p76 = w_p[7] & w_p[6];

    w_g30 = w_g32 | (w_p32 & w_g10);     w_p30 = w_p32 & w_p10;
    w_g74 = w_g76 | (w_p76 & w_g54);     w_p74 = w_p76 & w_p54;
    w_g70 = w_g74 | (w_p74 & w_g30);     w_p70 = w_p74 & w_p30;

    w_g50 = w_g54 | (w_p54 & w_g30);     w_p50 = w_p54 & w_p30;
    w_g20 = w_g[2] | (w_p[2] & w_g10);   w_p20 = w_p[2] & w_p10;
    w_g40 = w_g[4] | (w_p[4] & w_g30);   w_p40 = w_p[4] & w_p30;
    w_g60 = w_g[6] | (w_p[6] & w_g50);   w_p60 = w_p[6] & w_p50;

    w_gg = {w_g70, w_g60, w_g50, w_g40, w_g30, w_g20, w_g10, w_g[0]};
    w_pp = {w_p70, w_p60, w_p50, w_p40, w_p30, w_p20, w_p10, w_p[0]};

    w_c[0]   = i_cin;
    w_c[8:1] = w_gg | (w_pp & {8{i_cin}});

    o_sum  = w_p ^ w_c[7:0];
    o_cout = w_c[8];
  end

endmodule

// File: rtl/serial_bk_adder_32b.sv
// Byte-serial adder: one 8-bit Brent-Kung slice iterated over NUM_BYTES bytes.
module serial_bk_adder_32b
  import serial_adder_pkg::*;
#(
  parameter int unsigned NUM_BYTES = NUM_BYTES_DEFAULT
) (
  input logic                  clk_i,
  input logic                  rst_i,
  serial_bk_adder_32b_if.slave bus
);

  localparam int unsigned      W        = BYTE_W * NUM_BYTES;
  localparam int unsigned      IDX_W    = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_e             r_state, w_state_nxt;
  logic [W-1:0]       r_op1, r_op2, r_sum;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry, r_carry_o, r_ovf, r_valid;
  logic               w_ready, w_accept, w_last;
  logic [BYTE_W-1:0]  w_a, w_b, w_sum;
  logic               w_cout;

  assign w_ready  = (r_state == IDLE) && !rst_i;
  assign w_accept = bus.valid_i && w_ready;
  assign w_last   = (r_idx == LAST_IDX);

  assign w_a = r_op1[int'(r_idx)*BYTE_W +: BYTE_W];
  assign w_b = r_op2[int'(r_idx)*BYTE_W +: BYTE_W];

  brent_kung_adder_8b u_slice (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // State register with reset overriding any handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: accept in IDLE, leave RUN after the top byte, leave DONE on handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_state_nxt = RUN;
      RUN:     if (w_last)      w_state_nxt = DONE;
      DONE:    if (bus.ready_i) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands, write one sum byte per RUN cycle, publish flags on the last byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op1     <= '0;
      r_op2     <= '0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_sum     <= '0;
      r_carry_o <= 1'b0;
      r_ovf     <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op1   <= bus.op1_i;
            r_op2   <= bus.op2_i;
            r_carry <= bus.carry_i;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[int'(r_idx)*BYTE_W +: BYTE_W] <= w_sum;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_idx     <= '0;
            r_carry_o <= w_cout;
            r_ovf     <= signed_ovf(r_op1[W-1], r_op2[W-1], w_sum[BYTE_W-1]);
            r_valid   <= 1'b1;
          end
        end
        DONE: begin
          if (bus.ready_i) r_valid <= 1'b0;
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.valid_o = r_valid;
  assign bus.sum_o   = r_sum;
  assign bus.carry_o = r_carry_o;
  assign bus.ovf_o   = r_ovf;

endmodule

// File: doc/serial_bk_adder_32b.md
SERIAL_BK_ADDER_32B -- requirements
Module: serial_bk_adder_32b

Interface
REQ-001 SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter: NUM_BYTES, 4, number of 8-bit slices per operand; SHALL be at least 2.
REQ-003 Port: clk_i  in  1  rising-edge clock.
REQ-004 Port: rst_i  in  1  synchronous active-high reset.
REQ-005 Port: valid_i  in  1  operands and carry_i are valid.
REQ-006 Port: ready_o  out  1  block can accept an operation.
REQ-007 Port: op1_i, op2_i  in  8*NUM_BYTES  unsigned/two's-complement operands.
REQ-008 Port: carry_i  in  1  carry into byte 0.
REQ-009 Port: valid_o  out  1  result is valid.
REQ-010 Port: ready_i  in  1  downstream accepts the result.
REQ-011 Port: sum_o  out  8*NUM_BYTES  registered sum.
REQ-012 Port: carry_o  out  1  carry out of the MSB byte.
REQ-013 Port: ovf_o  out  1  signed overflow.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 ready_o SHALL be 1 only in IDLE with rst_i low.
REQ-016 valid_o SHALL be 1 only in DONE.
REQ-017 Accept: on an edge with valid_i=1 and ready_o=1, the block SHALL latch op1_i, op2_i and carry_i, clear the byte index to 0 and go to RUN.
REQ-018 In IDLE with valid_i=0, the block SHALL stay in IDLE and hold all outputs.
REQ-019 RUN: each cycle, byte k of the latched operands plus the carry register SHALL drive one 8-bit adder.
- On the edge, the adder's sum SHALL be written to sum byte k and its carry-out to the carry register.
- k SHALL then increment.
REQ-020 When byte NUM_BYTES-1 is written, the block SHALL go to DONE on that edge.
- valid_o SHALL therefore rise exactly NUM_BYTES edges after the accept edge.
REQ-021 In DONE, sum_o, carry_o and ovf_o SHALL be held stable until the edge where valid_o=1 and ready_i=1, then the block SHALL return to IDLE.
REQ-022 valid_i SHALL be ignored in RUN and DONE; the latched operands SHALL be unaffected.
REQ-023 carry_o SHALL equal the final carry register value.
REQ-024 ovf_o SHALL be 1 when the operand MSBs are equal and the sum MSB differs from them; otherwise 0.
REQ-025 Arithmetic SHALL be modulo 2^(8*NUM_BYTES); {carry_o,sum_o} SHALL equal op1+op2+carry_i exactly.
REQ-026 Throughput SHALL be one operation per NUM_BYTES+2 cycles minimum.
- There is no accept in the cycle of an output handshake.
REQ-027 sum_o SHALL retain the previous result in IDLE.
- Bytes SHALL update progressively during RUN.
- Downstream samples sum_o only on valid_o.

Reset
REQ-028 On an edge with rst_i=1: state=IDLE, byte index=0, carry register=0, sum_o=0, carry_o=0, ovf_o=0, valid_o=0.
REQ-029 ready_o SHALL be 0 while rst_i=1, and 1 in the cycle after reset deasserts.
REQ-030 Reset SHALL take priority over a simultaneous accept or output handshake.
- Reset in RUN or DONE SHALL abort the operation; no valid_o SHALL be produced for it.

Structure
REQ-031 Package serial_adder_pkg SHALL hold:
- the FSM state enum typedef;
- the BYTE_W=8 constant;
- the default NUM_BYTES constant.
REQ-032 The adder slice SHALL be one instance of the existing brent_kung_adder_8b.
- It SHALL be driven by the muxed byte k and the carry register.
- No other arithmetic sub-modules SHALL be used.
REQ-033 All outputs SHALL be driven from registers, except ready_o, which is decoded from state and rst_i.

Verification (NUM_BYTES=4)
REQ-034 Carry ripple: 0xFFFFFFFF + 0x00000001, carry_i=0, ready_i=1.
- sum_o=0x00000000, carry_o=1, ovf_o=0.
- valid_o high 4 edges after accept.
REQ-035 Signed overflow: 0x7FFFFFFF + 0x00000001, carry_i=0.
- sum_o=0x80000000, carry_o=0, ovf_o=1.
REQ-036 Carry-in: 0x12345678 + 0x9ABCDEF0, carry_i=1.
- sum_o=0xACF13569, carry_o=0, ovf_o=0.
REQ-037 Backpressure: hold ready_i=0 for 5 cycles in DONE while pulsing valid_i with new operands.
- valid_o stays 1, outputs unchanged, ready_o=0.
- After ready_i=1, ready_o=1 next cycle.
REQ-038 Mid-operation reset: assert rst_i 2 edges after accepting 0xFFFFFFFF+0x1.
- Next cycle: valid_o=0, sum_o=0, carry_o=0.
- ready_o=1 after deassertion.
- A new op 0x00000002+0x00000003 yields 0x00000005.
REQ-039 Random regression: 10k random operands and carry_i with random ready_i/valid_i gaps, checked against a 33-bit reference model.
- No lost or duplicated results.
